// File: rtl/parity_frame_ctrl.sv
// parity_frame_ctrl: frames a parallel payload into a serial line.
// Frame layout: start bit (0), DATA_W payload bits LSB first, one
// parity bit, stop bit (1). Every bit is held for CYC_PER_BIT clocks.
// The payload and parity sense are captured at accept, so input changes
// during a frame have no effect on it.
module parity_frame_ctrl #(
    parameter int DATA_W      = 8,
    parameter int CYC_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              odd_sel,
    input  logic              abort,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = (CYC_PER_BIT > 1) ? $clog2(CYC_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYC_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic              acc_q;   // running XOR of the payload bits sent so far
    logic              odd_q;   // parity sense captured at accept
    logic              tx_q;
    logic              done_q;

    logic              bit_end;
    logic [DATA_W-1:0] shift_nxt;

    // The final clock of each bit period; the counter counts down to zero.
    assign bit_end   = (cnt_q == '0);
    assign shift_nxt = shift_q >> 1;

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign tx_out     = tx_q;
    assign frame_done = done_q;

    // Frame sequencer; tx_out and frame_done are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            acc_q   <= 1'b0;
            odd_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if ((state_q != ST_IDLE) && abort) begin
                // Abandon the frame: line back to idle, no completion pulse.
                state_q <= ST_IDLE;
                tx_q    <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (in_valid) begin
                            shift_q <= in_data;
                            odd_q   <= odd_sel;
                            acc_q   <= 1'b0;
                            cnt_q   <= CNT_LAST;
                            idx_q   <= '0;
                            tx_q    <= 1'b0;
                            state_q <= ST_START;
                        end
                    end
                    ST_START: begin
                        if (bit_end) begin
                            cnt_q   <= CNT_LAST;
                            tx_q    <= shift_q[0];
                            state_q <= ST_DATA;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    ST_DATA: begin
                        if (bit_end) begin
                            acc_q <= acc_q ^ shift_q[0];
                            cnt_q <= CNT_LAST;
                            if (idx_q == IDX_LAST) begin
                                // Parity includes the bit just finished.
                                tx_q    <= acc_q ^ shift_q[0] ^ odd_q;
                                state_q <= ST_PARITY;
                            end else begin
                                idx_q   <= idx_q + IDX_W'(1);
                                shift_q <= shift_nxt;
                                tx_q    <= shift_nxt[0];
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    ST_PARITY: begin
                        if (bit_end) begin
                            cnt_q   <= CNT_LAST;
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    ST_STOP: begin
                        if (bit_end) begin
                            tx_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        tx_q    <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Bench for parity_frame_ctrl: one instance at one clock per bit, one at four.
module tb_parity_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [1:0][7:0] in_data;
    logic [1:0]      in_valid;
    logic [1:0]      odd_sel;
    logic [1:0]      abort_s;
    logic [1:0]      in_ready;
    logic [1:0]      tx_out;
    logic [1:0]      busy;
    logic [1:0]      frame_done;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          busy_cnt;
    logic [63:0] cap;

    parity_frame_ctrl #(.DATA_W(8), .CYC_PER_BIT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .odd_sel(odd_sel[0]), .abort(abort_s[0]),
        .tx_out(tx_out[0]), .busy(busy[0]), .frame_done(frame_done[0])
    );

    parity_frame_ctrl #(.DATA_W(8), .CYC_PER_BIT(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .odd_sel(odd_sel[1]), .abort(abort_s[1]),
        .tx_out(tx_out[1]), .busy(busy[1]), .frame_done(frame_done[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cyc_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    // Call at a negedge with instance k idle. Returns at the negedge of the
    // first idle cycle (frame_done cycle), or early after an abort/reset.
    task automatic run_frame(input int k, input logic [7:0] data, input logic odd,
                             input bit hold, input int abort_at, input int rst_at);
        logic exp_bits[$];
        logic par;
        logic lv;
        int   cyc;
        cyc = cyc_of(k);
        // Reference frame: ones in payload+parity is even for odd=0, odd for odd=1.
        par = (($countones(data) % 2) == 1) ^ odd;
        for (int b = 0; b < 11; b++) begin
            if (b == 0)      lv = 1'b0;
            else if (b <= 8) lv = data[b-1];
            else if (b == 9) lv = par;
            else             lv = 1'b1;
            repeat (cyc) exp_bits.push_back(lv);
        end
        check_val($sformatf("ready_pre%0d", k), in_ready[k], 1);
        in_valid[k] = 1'b1;
        in_data[k]  = data;
        odd_sel[k]  = odd;
        @(negedge clk);
        if (!hold) in_valid[k] = 1'b0;
        cap      = '0;
        busy_cnt = 0;
        for (int i = 0; i < exp_bits.size(); i++) begin
            check_val($sformatf("tx%0d_c%0d", k, i), tx_out[k], exp_bits[i]);
            check_val($sformatf("stat%0d_c%0d", k, i), {busy[k], frame_done[k], in_ready[k]}, 3'b100);
            cap      = {cap[62:0], tx_out[k]};
            busy_cnt = busy_cnt + int'(busy[k]);
            in_data[k] = 8'($urandom);
            odd_sel[k] = 1'($urandom);
            if (i == abort_at) begin
                abort_s[k] = 1'b1;
                @(negedge clk);
                abort_s[k] = 1'b0;
                check_val("abort_tx", tx_out[k], 1);
                check_val("abort_stat", {busy[k], frame_done[k], in_ready[k]}, 3'b001);
                @(negedge clk);
                check_val("abort_nodone", {tx_out[k], busy[k], frame_done[k], in_ready[k]}, 4'b1001);
                return;
            end
            if (i == rst_at) begin
                #3 rst_n = 1'b0;
                #1;
                check_val("rst_async_tx", tx_out[k], 1);
                check_val("rst_async_stat", {busy[k], frame_done[k], in_ready[k]}, 3'b001);
                @(posedge clk);
                @(negedge clk);
                check_val("rst_hold", {tx_out[k], busy[k], frame_done[k], in_ready[k]}, 4'b1001);
                #2 rst_n = 1'b1;
                return;
            end
            @(negedge clk);
        end
        check_val($sformatf("end%0d", k), {tx_out[k], busy[k], frame_done[k], in_ready[k]}, 4'b1011);
    endtask

    initial begin
        int k;
        int ab;
        bit hd;
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = '0;
        odd_sel  = '0;
        abort_s  = '0;
        #12;
        for (int j = 0; j < 2; j++)
            check_val($sformatf("reset%0d", j), {tx_out[j], busy[j], frame_done[j], in_ready[j]}, 4'b1001);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Known sequence at one clock per bit.
        run_frame(0, 8'hA5, 1'b0, 1'b0, -1, -1);
        check_val("seq_a5", cap[10:0], 11'b01010010101);

        // Parity sense.
        run_frame(0, 8'h07, 1'b0, 1'b0, -1, -1);
        check_val("par_07_even", cap[1], 1);
        run_frame(0, 8'h07, 1'b1, 1'b0, -1, -1);
        check_val("par_07_odd", cap[1], 0);
        run_frame(0, 8'h00, 1'b1, 1'b0, -1, -1);
        check_val("par_00_odd", cap[1], 1);

        // Four clocks per bit, all ones.
        run_frame(1, 8'hFF, 1'b0, 1'b0, -1, -1);
        check_val("busy_44", busy_cnt, 44);
        check_val("par_ff", cap[7:4], 4'b0000);

        // Back-to-back with in_valid held high.
        run_frame(0, 8'h3C, 1'b0, 1'b1, -1, -1);
        run_frame(0, 8'hC3, 1'b1, 1'b0, -1, -1);
        run_frame(1, 8'h81, 1'b1, 1'b1, -1, -1);
        run_frame(1, 8'h7E, 1'b0, 1'b0, -1, -1);

        // Abort during data bit 3, then a clean frame.
        run_frame(0, 8'h5A, 1'b0, 1'b0, 4, -1);
        run_frame(0, 8'h96, 1'b1, 1'b0, -1, -1);
        run_frame(1, 8'hE1, 1'b1, 1'b0, 4 * 4 + 2, -1);
        run_frame(1, 8'h1E, 1'b0, 1'b0, -1, -1);

        // Asynchronous reset during parity, then a clean frame.
        run_frame(1, 8'h33, 1'b1, 1'b0, -1, 9 * 4 + 1);
        run_frame(1, 8'hB4, 1'b0, 1'b0, -1, -1);

        // Randomized frames.
        repeat (24) begin
            in_valid = '0;
            k  = int'($urandom % 2);
            hd = 1'($urandom);
            ab = -1;
            if (!hd && ($urandom % 4 == 0)) ab = int'($urandom_range(0, 11 * cyc_of(k) - 1));
            run_frame(k, 8'($urandom), 1'($urandom), hd, ab, -1);
        end
        in_valid = '0;
        repeat (3) @(negedge clk);
        for (int j = 0; j < 2; j++)
            check_val($sformatf("final%0d", j), {tx_out[j], busy[j], frame_done[j], in_ready[j]}, 4'b1001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
